lvt_mpram: RTL
==============

LVT_MPRAM -- requirements
Module: lvt_mpram

Interface
Parameters:
REQ-001 SHALL provide DEPTH, default 1024, number of words per logical memory.
REQ-002 SHALL provide WIDTH, default 17, data bits per word.
REQ-003 SHALL provide NUM_RD, default 2, read port count; legal range 1..8.
REQ-004 SHALL provide NUM_WR, default 2, write port count; legal range 1..8.
REQ-005 SHALL provide RD_LAT, default 1, cycles from accepted ren to rvalid; legal range 1..4.
REQ-006 SHALL provide WR_MODE, default 0; 0 = read-first, 1 = write-first for same-cycle same-address access.
REQ-007 SHALL stop elaboration with $fatal if any parameter is outside its legal range.

Ports (AW = $clog2(DEPTH)):
REQ-008 clk  in  1  clock; all state updates on posedge clk.
REQ-009 rst_n  in  1  reset, synchronous, active-low.
REQ-010 raddr  in  [NUM_RD] x AW  read address per port.
REQ-011 ren  in  [NUM_RD] x 1  read request per port.
REQ-012 rdata  out  [NUM_RD] x WIDTH  read data per port.
REQ-013 rvalid  out  [NUM_RD] x 1  rdata qualifier per port.
REQ-014 waddr  in  [NUM_WR] x AW  write address per port.
REQ-015 wen  in  [NUM_WR] x 1  write enable per port.
REQ-016 wdata  in  [NUM_WR] x WIDTH  write data per port.
REQ-017 init_busy  out  1  high while post-reset memory clear runs.
REQ-018 wcollide  out  1  one-cycle pulse: two or more ports wrote the same address in the previous cycle.

Function
REQ-019 SHALL store data in NUM_WR x NUM_RD banks; write port w SHALL write all NUM_RD banks of group w.
REQ-020 SHALL keep a live value table (LVT) of DEPTH entries, each max(1,$clog2(NUM_WR)) bits, holding the index of the last writer per address.
REQ-021 Read port r SHALL return bank (LVT[raddr], r), selected with an LVT value read in the same cycle as the bank data.
REQ-022 Same-cycle writes to one address SHALL be resolved so the highest-indexed write port wins in both banks and LVT; wcollide SHALL pulse high on the next cycle.
REQ-023 ren accepted at cycle t SHALL give rvalid high and rdata valid at cycle t+RD_LAT; the pipeline SHALL advance every cycle regardless of ren, so back-to-back reads give one result per cycle.
REQ-024 rdata SHALL hold its last valid value while rvalid is low.
REQ-025 WR_MODE=0: a read at cycle t of an address written at cycle t SHALL return the pre-write value.
REQ-026 WR_MODE=1: that read SHALL return the winning wdata of cycle t, bypassing the banks.
REQ-027 A read at cycle t+1 or later of an address written at cycle t SHALL return the new value in both modes.
REQ-028 Addresses >= DEPTH SHALL be ignored: such writes are dropped and such reads still produce rvalid with rdata = 0.
REQ-029 Init FSM states: CLEAR, RUN.
 - Reset enters CLEAR with counter 0.
 - CLEAR writes 0 to every bank and sets LVT to 0 at the counter address, one address per cycle.
 - CLEAR moves to RUN after address DEPTH-1, taking exactly DEPTH cycles.
REQ-030 In CLEAR: init_busy = 1, wen and ren ignored, no rvalid generated.
REQ-031 In RUN: init_busy = 0.

Reset
REQ-032 While rst_n = 0 at a clock edge:
 - rvalid = 0, rdata = 0, wcollide = 0, init_busy = 1;
 - read pipeline cleared, init counter = 0.
REQ-033 Reset asserted mid-CLEAR or mid-read SHALL restart CLEAR from address 0 and discard in-flight reads (no rvalid for them).

Verification
REQ-034 Reset, then poll: init_busy = 1 for exactly DEPTH cycles; every subsequent read of all addresses returns 0.
REQ-035 Defaults: wen0 addr 5 = 0x1AAAA at t, wen1 addr 9 = 0x00055 at t. At t+1 read port0 addr 5, port1 addr 9 -> at t+2 rvalid = 11, rdata0 = 0x1AAAA, rdata1 = 0x00055.
REQ-036 Both write ports write addr 7 at t (0x11, 0x22) -> wcollide = 1 at t+1 only; later reads of addr 7 on both ports = 0x22.
REQ-037 Addr 3 holds 0x10; at t write 0x20 to addr 3 and read addr 3 -> WR_MODE=0 returns 0x10, WR_MODE=1 returns 0x20, each at t+RD_LAT.
REQ-038 NUM_RD = 3, NUM_WR = 4, RD_LAT = 3: 100 random cycles against a reference model. ren on consecutive cycles -> consecutive rvalid after exactly 3 cycles; reset asserted mid-stream -> no stale rvalid afterwards.

Source files
------------

// File: rtl/lvt_mpram.sv
// Multi-port RAM with NUM_WR x NUM_RD banks and a live value table (LVT) that records the last writer.
// Latency: rdata/rvalid arrive RD_LAT cycles after an accepted ren. All ports are always ready; a post-reset clear blocks access for DEPTH cycles.
// Ports: clk/rst_n (sync, active-low); raddr/ren/rdata/rvalid per read port; waddr/wen/wdata per write port; init_busy; wcollide.
module lvt_mpram #(
  parameter int DEPTH   = 1024,
  parameter int WIDTH   = 17,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 2,
  parameter int RD_LAT  = 1,
  parameter int WR_MODE = 0,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_RD-1:0][AW-1:0]     raddr,
  input  logic [NUM_RD-1:0]             ren,
  output logic [NUM_RD-1:0][WIDTH-1:0]  rdata,
  output logic [NUM_RD-1:0]             rvalid,
  input  logic [NUM_WR-1:0][AW-1:0]     waddr,
  input  logic [NUM_WR-1:0]             wen,
  input  logic [NUM_WR-1:0][WIDTH-1:0]  wdata,
  output logic                          init_busy,
  output logic                          wcollide
);

  localparam int              LW      = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam logic [AW:0]     DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

  if (DEPTH < 2 || WIDTH < 1 || NUM_RD < 1 || NUM_RD > 8 || NUM_WR < 1 || NUM_WR > 8 ||
      RD_LAT < 1 || RD_LAT > 4 || (WR_MODE != 0 && WR_MODE != 1)) begin : g_param_chk
    $fatal(1, "lvt_mpram: parameter outside legal range");
  end

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                       state_q;
  logic [AW-1:0]                cnt_q;
  logic                         busy_q;
  logic                         wcollide_q;
  logic                         wcollide_d;

  logic [WIDTH-1:0]             mem_q [NUM_WR][NUM_RD][DEPTH];
  logic [LW-1:0]                lvt_q [DEPTH];

  logic [NUM_WR-1:0]            wact;
  logic [NUM_RD-1:0]            racc;
  logic [NUM_RD-1:0][WIDTH-1:0] rd_d;

  logic [NUM_RD-1:0]            pv_q [RD_LAT];
  logic [NUM_RD-1:0][WIDTH-1:0] pd_q [RD_LAT];
  logic [NUM_RD-1:0]            st_v [RD_LAT];
  logic [NUM_RD-1:0][WIDTH-1:0] st_d [RD_LAT];

  wire run = rst_n && (state_q == RUN);

  // Accepted writes: running and in range. Out-of-range writes vanish here.
  always_comb begin
    wcollide_d = 1'b0;
    for (int w = 0; w < NUM_WR; w++) begin
      wact[w] = run && wen[w] && ({1'b0, waddr[w]} < DEPTH_L);
    end
    for (int a = 0; a < NUM_WR; a++) begin
      for (int b = a + 1; b < NUM_WR; b++) begin
        if (wact[a] && wact[b] && waddr[a] == waddr[b]) wcollide_d = 1'b1;
      end
    end
  end

  // Write group w owns banks [w][*]; every read port gets its own replica.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WR; w++) begin
      for (int r = 0; r < NUM_RD; r++) begin
        if (rst_n && state_q == CLEAR) mem_q[w][r][cnt_q] <= '0;
        else if (wact[w])              mem_q[w][r][waddr[w]] <= wdata[w];
      end
    end
  end

  // Ascending loop: on a shared address the highest-indexed port's write lands last and wins.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == CLEAR) begin
      lvt_q[cnt_q] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wact[w]) lvt_q[waddr[w]] <= LW'(w);
      end
    end
  end

  // Read stage: LVT and banks are sampled together, so a same-cycle write is not yet visible
  // (read-first). Write-first mode forwards the winning wdata instead.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      racc[r] = run && ren[r];
      rd_d[r] = '0;
      if ({1'b0, raddr[r]} < DEPTH_L) begin
        rd_d[r] = mem_q[lvt_q[raddr[r]]][r][raddr[r]];
        if (WR_MODE == 1) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (wact[w] && waddr[w] == raddr[r]) rd_d[r] = wdata[w];
          end
        end
      end
    end
  end

  always_comb begin
    st_v[0] = racc;
    st_d[0] = rd_d;
    for (int s = 1; s < RD_LAT; s++) begin
      st_v[s] = pv_q[s-1];
      st_d[s] = pd_q[s-1];
    end
  end

  // Free-running pipeline; only the output stage holds its data while no result arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        pv_q[s] <= '0;
        pd_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < RD_LAT; s++) begin
        pv_q[s] <= st_v[s];
        for (int r = 0; r < NUM_RD; r++) begin
          if (s < RD_LAT - 1 || st_v[s][r]) pd_q[s][r] <= st_d[s][r];
        end
      end
    end
  end

  // Init FSM: one address cleared per cycle, DEPTH cycles in total.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      wcollide_q <= 1'b0;
    end else begin
      wcollide_q <= wcollide_d;
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == LAST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rvalid    = pv_q[RD_LAT-1];
  assign rdata     = pd_q[RD_LAT-1];
  assign init_busy = busy_q;
  assign wcollide  = wcollide_q;

endmodule
